// File: rtl/fc_neuron_seq_pkg.sv
// Shared types and helpers for the time-multiplexed fully-connected neuron.
package fc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      OUT   = 2'd2
   } fc_state_t;

   // Widest accumulator the ReLU helper can carry.
   localparam int MAX_ACC_W = 64;

   // Accumulator width: full product width, growth for IN terms, plus one guard bit for the bias.
   function automatic int acc_width(input int width, input int in_len);
      return (width * 2) + $clog2(in_len) + 1;
   endfunction

   // Clamp negative values to zero when enabled; an exact zero passes unchanged.
   function automatic logic signed [MAX_ACC_W-1:0] relu(input logic signed [MAX_ACC_W-1:0] value,
                                                       input int relu_en);
      logic signed [MAX_ACC_W-1:0] res;
      if ((relu_en != 0) && value[MAX_ACC_W-1]) begin
         res = {MAX_ACC_W{1'b0}};
      end else begin
         res = value;
      end
      return res;
   endfunction

endpackage

// File: rtl/fc_neuron_seq_lane_mac.sv
// Combinational per-beat multiply and balanced adder tree over LANES signed lane products.
module lane_mac
   import fc_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int LANES = 8,
   localparam int SUM_W = WIDTH * 2 + $clog2(LANES)
) (
   input  logic [LANES*WIDTH-1:0] x,
   input  logic [LANES*WIDTH-1:0] w,
   output logic signed [SUM_W-1:0] sum
);

   localparam int LEVELS = $clog2(LANES);
   localparam int PROD_W = WIDTH * 2;

   logic signed [PROD_W-1:0] prod_s [LANES];
   logic signed [SUM_W-1:0]  node_s [LANES];
   int                       live_s;

   // Form lane products, then reduce pairwise in place; an unpaired node passes up sign-extended.
   always_comb begin
      live_s = LANES;
      for (int k = 0; k < LANES; k++) begin
         prod_s[k] = PROD_W'($signed(x[k*WIDTH +: WIDTH])) * PROD_W'($signed(w[k*WIDTH +: WIDTH]));
         node_s[k] = SUM_W'(prod_s[k]);
      end
      for (int lvl = 0; lvl < LEVELS; lvl++) begin
         for (int k = 0; k < LANES / 2; k++) begin
            if (k < ((live_s + 1) / 2)) begin
               if (((2 * k) + 1) < live_s) begin
                  node_s[k] = node_s[2*k] + node_s[(2*k)+1];
               end else begin
                  node_s[k] = node_s[2*k];
               end
            end else begin
               node_s[k] = node_s[k];
            end
         end
         live_s = (live_s + 1) / 2;
      end
      sum = node_s[0];
   end

endmodule

// File: rtl/fc_neuron_seq.sv
// Time-multiplexed FC neuron: accumulates IN/LANES beats, adds BIAS, optional ReLU, emits one result.
module fc_neuron_seq
   import fc_pkg::*;
#(
   parameter  int WIDTH   = 8,
   parameter  int IN      = 128,
   parameter  int LANES   = 8,
   parameter  int BIAS    = 0,
   parameter  int RELU_EN = 1,
   localparam int ACC_W   = acc_width(WIDTH, IN)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*WIDTH-1:0] x,
   input  logic [LANES*WIDTH-1:0] w,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ACC_W-1:0]       z,
   output logic                   busy
);

   localparam int BEATS = IN / LANES;
   localparam int CNT_W = $clog2(BEATS) + 1;
   localparam int SUM_W = WIDTH * 2 + $clog2(LANES);
   localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(BEATS - 1);
   localparam logic signed [ACC_W-1:0] BIAS_ACC = ACC_W'(BIAS);

   generate
      if ((IN % LANES) != 0) begin : g_in_check
         $error("fc_neuron_seq: IN must be a multiple of LANES");
      end
      if ((LANES < 1) || (LANES > IN) || ((LANES & (LANES - 1)) != 0)) begin : g_lanes_check
         $error("fc_neuron_seq: LANES must be a power of two in 1..IN");
      end
      if (ACC_W > MAX_ACC_W) begin : g_width_check
         $error("fc_neuron_seq: accumulator wider than the ReLU helper supports");
      end
   endgenerate

   fc_state_t               state_r, state_nxt_s;
   logic signed [ACC_W-1:0] acc_r, acc_nxt_s;
   logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
   logic signed [ACC_W-1:0] z_r, z_nxt_s;
   logic                    out_valid_r, out_valid_nxt_s;
   logic                    busy_r, busy_nxt_s;
   logic                    in_ready_s;

   logic signed [SUM_W-1:0] beat_sum_s;
   logic signed [ACC_W-1:0] acc_sum_s;
   logic signed [ACC_W-1:0] final_s;
   logic                    beat_s;
   logic                    last_s;

   lane_mac #(
      .WIDTH (WIDTH),
      .LANES (LANES)
   ) u_lane_mac (
      .x   (x),
      .w   (w),
      .sum (beat_sum_s)
   );

   // In IDLE the counter is zero, so a single-beat vector is recognised as last immediately.
   assign beat_s    = in_valid & in_ready_s;
   assign last_s    = (cnt_r == LAST_CNT);
   assign acc_sum_s = acc_r + ACC_W'(beat_sum_s);
   assign final_s   = acc_sum_s + BIAS_ACC;

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign z         = z_r;
   assign busy      = busy_r;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode: accumulate beats, park in OUT until the result is taken.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (beat_s) begin
               state_nxt_s = last_s ? OUT : ACCUM;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACCUM: begin
            if (beat_s && last_s) begin
               state_nxt_s = OUT;
            end else begin
               state_nxt_s = ACCUM;
            end
         end
         OUT: begin
            if (out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = OUT;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Output and datapath decode: next accumulator, counter, result and handshake flags.
   always_comb begin
      in_ready_s      = (state_r != OUT);
      acc_nxt_s       = acc_r;
      cnt_nxt_s       = cnt_r;
      z_nxt_s         = z_r;
      out_valid_nxt_s = out_valid_r;
      busy_nxt_s      = busy_r;
      if (beat_s) begin
         acc_nxt_s  = acc_sum_s;
         cnt_nxt_s  = cnt_r + CNT_W'(1);
         busy_nxt_s = 1'b1;
         if (last_s) begin
            z_nxt_s         = ACC_W'(relu(MAX_ACC_W'(final_s), RELU_EN));
            out_valid_nxt_s = 1'b1;
         end else begin
            out_valid_nxt_s = out_valid_r;
         end
      end else if ((state_r == OUT) && out_ready) begin
         acc_nxt_s       = {ACC_W{1'b0}};
         cnt_nxt_s       = {CNT_W{1'b0}};
         out_valid_nxt_s = 1'b0;
         busy_nxt_s      = 1'b0;
      end else begin
         acc_nxt_s = acc_r;
      end
   end

   // Datapath registers; reset discards any partial sum and pending result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r       <= {ACC_W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         z_r         <= {ACC_W{1'b0}};
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         acc_r       <= acc_nxt_s;
         cnt_r       <= cnt_nxt_s;
         z_r         <= z_nxt_s;
         out_valid_r <= out_valid_nxt_s;
         busy_r      <= busy_nxt_s;
      end
   end

endmodule
